// File: rtl/sstv_vis.sv
// sstv_vis: decodes the 8-bit SSTV VIS word (7-bit mode code + even parity) after cal_ok rises.
// Build option: define SSTV_VIS_TOL_EN for +/-FREQ_TOL tone bands; undefined means exact-match bands.
module sstv_vis #(
  parameter int          simulate = 0,
  parameter logic [11:0] FREQ_TOL = 12'd25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] freq,
  input  logic        cal_ok,
  output logic        vis_active,
  output logic [6:0]  vis_code,
  output logic        vis_valid,
  output logic        vis_parity_err,
  output logic        vis_abort
);

  localparam logic [31:0] BIT_TICKS  = (simulate != 0) ? 32'd3_000 : 32'd3_000_000;
  localparam logic [31:0] HALF_TICKS = (simulate != 0) ? 32'd1_500 : 32'd1_500_000;

  // Exact matching is the zero-width case of the toleranced comparison.
`ifdef SSTV_VIS_TOL_EN
  localparam logic [12:0] TOL = {1'b0, FREQ_TOL};
`else
  localparam logic [12:0] TOL = 13'd0 & {1'b0, FREQ_TOL};
`endif

  function automatic logic in_band(input logic [11:0] f, input logic [11:0] centre);
    logic [12:0] f13;
    logic [12:0] c13;
    f13 = {1'b0, f};
    c13 = {1'b0, centre};
    return ((f13 + TOL) >= c13) && (f13 <= (c13 + TOL));
  endfunction

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  state_t      state;
  logic [31:0] counter;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        cal_ok_q;

  logic arm;
  logic b1100;
  logic b1200;
  logic b1300;
  logic half_hit;
  logic bit_hit;

  assign arm      = cal_ok & ~cal_ok_q;
  assign b1100    = in_band(freq, 12'd1100);
  assign b1200    = in_band(freq, 12'd1200);
  assign b1300    = in_band(freq, 12'd1300);
  assign half_hit = (counter == HALF_TICKS - 32'd1);
  assign bit_hit  = (counter == BIT_TICKS - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= 32'd0;
      bit_idx        <= 3'd0;
      shreg          <= 8'd0;
      cal_ok_q       <= 1'b0;
      vis_active     <= 1'b0;
      vis_code       <= 7'd0;
      vis_valid      <= 1'b0;
      vis_parity_err <= 1'b0;
      vis_abort      <= 1'b0;
    end else begin
      cal_ok_q       <= cal_ok;
      vis_active     <= (state != IDLE);
      vis_valid      <= 1'b0;
      vis_parity_err <= 1'b0;
      vis_abort      <= 1'b0;
      case (state)
        IDLE: begin
          counter <= 32'd0;
          if (arm) state <= START;
        end
        START: begin
          if (half_hit) begin
            counter <= 32'd0;
            if (b1200) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state     <= IDLE;
              vis_abort <= 1'b1;
            end
          end else begin
            counter <= counter + 32'd1;
          end
        end
        DATA: begin
          if (bit_hit) begin
            counter <= 32'd0;
            if (b1100 || b1300) begin
              // LSB first: after 8 bits shreg[6:0] is the code and shreg[7] the parity bit.
              shreg <= {b1100, shreg[7:1]};
              if (bit_idx == 3'd7) state <= STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              state     <= IDLE;
              vis_abort <= 1'b1;
            end
          end else begin
            counter <= counter + 32'd1;
          end
        end
        STOP: begin
          if (bit_hit) begin
            counter <= 32'd0;
            state   <= IDLE;
            if (b1200) begin
              if ((^shreg[6:0]) == shreg[7]) begin
                vis_valid <= 1'b1;
                vis_code  <= shreg[6:0];
              end else begin
                vis_parity_err <= 1'b1;
              end
            end else begin
              vis_abort <= 1'b1;
            end
          end else begin
            counter <= counter + 32'd1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= 32'd0;
        end
      endcase
    end
  end

endmodule
